// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, single-outstanding imem fetch, prefetch FIFO and decode field split.
// Optional FETCH_MISALIGN_CHECK_EN adds fetch_fault and a HALT state for misaligned redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic [6:0]  cu_op,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    S_HALT
`endif
  } state_t;
  state_t state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic out_q, out_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [63:0] mem_q [FIFO_DEPTH];
  logic [63:0] mem_d [FIFO_DEPTH];
  logic [63:0] head;
  logic credit, req_fire, rsp_take, push, pop;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q, fault_d, bad;
  assign fetch_fault = fault_q;
`endif
  // Request/decode outputs, FIFO bookkeeping and the redirect-first next-state rules.
  always_comb begin
    credit = 32'(count_q) + 32'(out_q) < 32'(FIFO_DEPTH);
    imem_req_valid = rst_n && state_q == S_REQ && credit;
    imem_req_addr = fetch_pc_q;
    ir_valid = count_q != '0;
    head = ir_valid ? mem_q[rd_q] : '0;
    pc = head[63:32];
    ir = head[31:0];
    cu_op = head[6:0];
    funct3 = head[14:12];
    funct7 = head[31:25];
    req_fire = imem_req_valid && imem_req_ready;
    rsp_take = imem_rsp_valid && out_q;
    push = rsp_take && state_q == S_WAIT && !redirect_valid;
    pop = ir_valid && ir_ready && !redirect_valid;
    out_d = req_fire || (out_q && !imem_rsp_valid);
    state_d = redirect_valid ? (out_d ? S_DROP : S_REQ)
            : req_fire ? S_WAIT
            : (rsp_take && (state_q == S_WAIT || state_q == S_DROP)) ? S_REQ
            : state_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    bad = redirect_pc[1:0] != 2'b00;
    state_d = (redirect_valid && bad) ? S_HALT : state_d;
    fault_d = redirect_valid ? bad : fault_q;
`endif
    fetch_pc_d = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC)
               : req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
    rsp_pc_d = req_fire ? fetch_pc_q : rsp_pc_q;
    count_d = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
    wr_d = redirect_valid ? '0 : wr_q + PW'(push);
    rd_d = redirect_valid ? '0 : rd_q + PW'(pop);
    mem_d = mem_q;
    if (push) mem_d[wr_q] = {rsp_pc_q, imem_rsp_data};
  end
  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q <= '0;
      out_q <= 1'b0;
      count_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q <= out_d;
      count_q <= count_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end
  // FIFO storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit with a sequential-stream reference model.
module tb_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;
  logic clk = 1'b0, rst_n = 1'b0;
  logic imem_req_valid, imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic ir_valid, ir_ready = 1'b0;
  logic [31:0] ir, pc;
  logic [6:0] cu_op, funct7;
  logic [2:0] funct3;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic fetch_fault;
`endif
  int checks = 0, errors = 0, pops = 0;
  int lat_mode = 1;
  bit rdy_force = 1'b1, hold_req = 1'b0;
  logic [31:0] exp_q [$];

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .pc(pc),
    .cu_op(cu_op), .funct3(funct3), .funct7(funct7)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .fetch_fault(fetch_fault)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic timeout(input string n);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting, got nothing expected event", n);
  endtask

  // Reference model: decode sees consecutive words from the latest redirect target (or RESET_PC).
  task automatic sb_load(input logic [31:0] a);
    exp_q.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
    if (a[1:0] != 2'b00) return;
`endif
    for (int i = 0; i < 1000; i++) exp_q.push_back((a & 32'hFFFF_FFFC) + 32'(4 * i));
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    sb_load(RPC);
  endtask

  task automatic do_redirect(input logic [31:0] a);
    @(posedge clk); #2;
    redirect_valid = 1'b1;
    redirect_pc = a;
    sb_load(a);
    @(posedge clk); #2;
    redirect_valid = 1'b0;
  endtask

  task automatic wait_ir(input string n);
    int k = 0;
    do begin @(negedge clk); k++; end while (!ir_valid && k < 100);
    if (!ir_valid) timeout(n);
  endtask

  task automatic wait_fire(input string n);
    int k = 0;
    do begin @(negedge clk); k++; end while (!(imem_req_valid && imem_req_ready) && k < 100);
    if (!(imem_req_valid && imem_req_ready)) timeout(n);
  endtask

  task automatic until_req(input string n);
    int k = 0;
    while (!imem_req_valid && k < 100) begin @(negedge clk); k++; end
    if (!imem_req_valid) timeout(n);
  endtask

  // Memory model: accepts requests, answers after 1..3 cycles with mem_word of the address.
  initial begin : memory
    bit fire, pend;
    logic [31:0] faddr, paddr;
    int left;
    pend = 1'b0; paddr = '0; left = 0;
    forever begin
      @(negedge clk);
      fire = imem_req_valid && imem_req_ready;
      faddr = imem_req_addr;
      if (fire) chk("one_outstanding", 32'(pend), 32'd0);
      @(posedge clk); #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = '0;
      if (fire) begin
        pend = 1'b1;
        paddr = faddr;
        left = (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
      end
      if (pend) begin
        if (left <= 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data = mem_word(paddr);
          pend = 1'b0;
        end else left--;
      end
      imem_req_ready = hold_req ? 1'b0 : rdy_force ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on each decode handshake and checks request-channel stability.
  logic p_v = 1'b0, p_r = 1'b0, p_redir = 1'b0, p_rst = 1'b0;
  logic [31:0] p_addr = '0;
  always @(negedge clk) begin : mon
    logic [31:0] e, w;
    if (rst_n && ir_valid && ir_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ir_unexpected: got pc %h expected no instruction", pc);
      end else begin
        e = exp_q.pop_front();
        w = mem_word(e);
        pops++;
        chk("ir_pc", pc, e);
        chk("ir_word", ir, w);
        chk("ir_fields", {15'b0, cu_op, funct3, funct7}, {15'b0, w[6:0], w[14:12], w[31:25]});
      end
    end else if (!ir_valid) begin
      chk("empty_ir", ir, 32'd0);
      chk("empty_pc", pc, 32'd0);
      chk("empty_fields", {15'b0, cu_op, funct3, funct7}, 32'd0);
    end
    if (rst_n && p_rst && p_v && !p_r && !p_redir) begin
      chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
      chk("req_hold_addr", imem_req_addr, p_addr);
    end
    if (imem_req_valid) chk("req_aligned", {30'b0, imem_req_addr[1:0]}, 32'd0);
    p_v = imem_req_valid;
    p_r = imem_req_ready;
    p_redir = redirect_valid;
    p_rst = rst_n;
    p_addr = imem_req_addr;
  end

  initial begin : main
    int n;
    bit got, gap, seen;
    logic [31:0] ra, a;
    #3;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_fields", {15'b0, cu_op, funct3, funct7}, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_fault", 32'(fetch_fault), 32'd0);
`endif
    @(posedge clk); #2;
    rst_n = 1'b1;
    sb_load(RPC);
    ir_ready = 1'b1;
    @(negedge clk);
    n = 1;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, RPC);
    while (!ir_valid && n < 20) begin @(negedge clk); n++; end
    chk("first_ir_latency", 32'(n), 32'd3);
    chk("first_ir", ir, 32'h0050_0093);
    chk("first_pc", pc, 32'h0);
    chk("first_cu_op", 32'(cu_op), 32'h13);
    chk("first_funct3", 32'(funct3), 32'h0);
    chk("first_funct7", 32'(funct7), 32'h0);
    wait_ir("second_ir");
    chk("second_pc", pc, 32'h4);

    @(posedge clk); #2;
    ir_ready = 1'b0;
    do_reset();
    repeat (10) @(negedge clk);
    chk("full_ir_valid", 32'(ir_valid), 32'd1);
    chk("full_no_req", 32'(imem_req_valid), 32'd0);
    chk("full_head_pc", pc, 32'h0);
    @(posedge clk); #2;
    ir_ready = 1'b1;
    lat_mode = 3;
    n = 0; got = 1'b0; gap = 1'b0; ra = '0;
    for (int i = 0; i < 40 && !(got && gap); i++) begin
      @(negedge clk);
      if (imem_req_valid && !got) begin got = 1'b1; ra = imem_req_addr; end
      if (ir_valid && !gap) n++;
      else gap = 1'b1;
    end
    chk("drain_count", 32'(n), 32'(DEPTH));
    chk("resume_addr", ra, 32'h8);

    do_redirect(32'h100);
    seen = 1'b0; n = 0;
    do begin
      @(negedge clk);
      n++;
      if (imem_rsp_valid) seen = 1'b1;
    end while (!imem_req_valid && n < 50);
    chk("drop_waited_rsp", 32'(seen), 32'd1);
    chk("redirect_req_valid", 32'(imem_req_valid), 32'd1);
    chk("redirect_req_addr", imem_req_addr, 32'h100);
    lat_mode = 1;
    wait_ir("redirect_ir");
    chk("redirect_ir_pc", pc, 32'h100);

    wait_fire("rsp_redirect_fire");
    @(posedge clk); #2;
    chk("rsp_redirect_rsp_valid", 32'(imem_rsp_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    sb_load(32'h300);
    @(posedge clk); #2;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("rsp_redirect_empty", 32'(ir_valid), 32'd0);
    wait_ir("rsp_redirect_ir");
    chk("rsp_redirect_pc", pc, 32'h300);

`ifdef FETCH_MISALIGN_CHECK_EN
    do_redirect(32'h102);
    @(negedge clk);
    chk("fault_set", 32'(fetch_fault), 32'd1);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (imem_req_valid || ir_valid) seen = 1'b1;
    end
    chk("halt_quiet", 32'(seen), 32'd0);
    do_redirect(32'h200);
    @(negedge clk);
    chk("fault_clear", 32'(fetch_fault), 32'd0);
    until_req("halt_exit_req");
    chk("halt_exit_addr", imem_req_addr, 32'h200);
`else
    do_redirect(32'h102);
    @(negedge clk);
    until_req("misalign_req");
    chk("misalign_addr", imem_req_addr, 32'h100);
`endif

    lat_mode = 3;
    wait_fire("wait_reset_fire");
    @(posedge clk); #2;
    hold_req = 1'b1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("mid_rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("mid_rst_ir", ir, 32'd0);
    chk("mid_rst_pc", pc, 32'd0);
    chk("mid_rst_fields", {15'b0, cu_op, funct3, funct7}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    sb_load(RPC);
    n = 0;
    do begin @(negedge clk); n++; end while (!imem_rsp_valid && n < 20);
    chk("late_rsp_seen", 32'(imem_rsp_valid), 32'd1);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ir_valid) seen = 1'b1;
    end
    chk("late_rsp_ignored", 32'(seen), 32'd0);
    @(posedge clk); #2;
    hold_req = 1'b0;
    lat_mode = 1;
    wait_fire("restart_fire");
    chk("restart_addr", imem_req_addr, RPC);
    wait_ir("restart_ir");
    chk("restart_pc", pc, RPC);

    rdy_force = 1'b0;
    lat_mode = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      ir_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 3))
          0: a = $urandom & 32'hFFFF_FFFC;
          1: a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
          2: a = 32'($urandom_range(0, 255) * 4);
          default: a = $urandom | 32'h1;
        endcase
        redirect_valid = 1'b1;
        redirect_pc = a;
        sb_load(a);
      end else redirect_valid = 1'b0;
    end
    @(posedge clk); #2;
    redirect_valid = 1'b0;
    ir_ready = 1'b1;
    repeat (50) @(negedge clk);
    chk("stream_progress", (pops > 200) ? 32'd1 : 32'd0, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
